data_mem_hs: RTL and testbench



---
 rtl/data_mem_hs.sv | 118 +++++++++++
 tb/tb_data_mem_hs.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_hs.sv
// data_mem_hs: handshaked byte-addressed data RAM with size decode, extension and error response
module data_mem_hs #(
   parameter int          ADDR_WIDTH  = 32,
   parameter int          DEPTH       = 256,
   parameter int          WAIT_CYCLES = 0,
   parameter logic [31:0] INIT_VALUE  = 32'hDEADBEEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err
);
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] addr;
      logic [1:0]            size;
      logic                  uns;
      logic [31:0]           wdata;
   } req_t;
   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   req_t        req_q, req_d;
   logic        valid_q, valid_d, err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] mem_q [DEPTH] = '{default: INIT_VALUE};
   logic [1:0]  lane;
   logic [IW-1:0] idx;
   logic        oor, err, commit;
   logic [3:0]  be;
   logic [31:0] wd, rword, ext;
   logic [7:0]  bsel;
   logic [15:0] hsel;
   assign lane   = req_q.addr[1:0];
   assign idx    = req_q.addr[IW+1:2];
   // high address bits take part in the range check, so no aliasing onto low words
   assign oor    = {1'b0, req_q.addr[ADDR_WIDTH-1:2]} >= (ADDR_WIDTH-1)'(DEPTH);
   assign err    = req_q.size == 2'b11 || (req_q.size == 2'b01 && lane[0]) ||
                   (req_q.size == 2'b10 && lane != 2'b00) || oor;
   assign commit = state_q == S_RESP && !valid_q;
   assign be     = req_q.size == 2'b00 ? 4'b0001 << lane :
                   req_q.size == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign wd     = req_q.size == 2'b00 ? {4{req_q.wdata[7:0]}} :
                   req_q.size == 2'b01 ? {2{req_q.wdata[15:0]}} : req_q.wdata;
   assign rword  = mem_q[idx];
   assign bsel   = rword[{lane, 3'b000} +: 8];
   assign hsel   = lane[1] ? rword[31:16] : rword[15:0];
   assign ext    = req_q.size == 2'b00 ? {{24{~req_q.uns & bsel[7]}}, bsel} :
                   req_q.size == 2'b01 ? {{16{~req_q.uns & hsel[15]}}, hsel} : rword;
   assign req_ready = state_q == S_IDLE;
   assign rsp_valid = valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   always_ff @(posedge clk)
      if (commit && req_q.we && !err)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem_q[idx][8*i +: 8] <= wd[8*i +: 8];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         valid_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         valid_q <= valid_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   // RESP with valid_q low is the single commit edge; valid_q high is the hold phase
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      valid_d = valid_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE:
            if (req_valid) begin
               req_d = '{we: req_we, addr: req_addr, size: req_size, uns: req_unsigned, wdata: req_wdata};
               if (WAIT_CYCLES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end else state_d = S_RESP;
            end
         S_WAIT:
            if (cnt_q == 4'd0) state_d = S_RESP;
            else cnt_d = cnt_q - 4'd1;
         S_RESP:
            if (!valid_q) begin
               valid_d = 1'b1;
               err_d   = err;
               rdata_d = (req_q.we || err) ? 32'd0 : ext;
            end else if (rsp_ready) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_data_mem_hs.sv
// tb_data_mem_hs: scoreboard bench for data_mem_hs with zero and three wait states
module tb_data_mem_hs;
   typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
   logic        clk;
   logic        rst_n [2];
   logic        req_valid [2], req_ready [2], req_we [2], req_unsigned [2];
   logic [31:0] req_addr [2], req_wdata [2];
   logic [1:0]  req_size [2];
   logic        rsp_valid [2], rsp_ready [2], rsp_err [2];
   logic [31:0] rsp_rdata [2];
   exp_t        q0 [$], q1 [$];
   int          n_chk = 0, n_fail = 0;
   data_mem_hs #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
      .req_unsigned(req_unsigned[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
      .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));
   data_mem_hs #(.WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
      .req_unsigned(req_unsigned[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
      .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask
   always @(negedge clk)
      if (rsp_valid[0] && rsp_ready[0]) begin
         exp_t e0;
         if (q0.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb0_unexpected: got rdata=%h err=%b, required no response", rsp_rdata[0], rsp_err[0]);
         end else begin
            e0 = q0.pop_front();
            chk("sb0_rdata", rsp_rdata[0], e0.rdata);
            chk("sb0_err", 32'(rsp_err[0]), 32'(e0.err));
         end
      end
   always @(negedge clk)
      if (rsp_valid[1] && rsp_ready[1]) begin
         exp_t e1;
         if (q1.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb3_unexpected: got rdata=%h err=%b, required no response", rsp_rdata[1], rsp_err[1]);
         end else begin
            e1 = q1.pop_front();
            chk("sb3_rdata", rsp_rdata[1], e1.rdata);
            chk("sb3_err", 32'(rsp_err[1]), 32'(e1.err));
         end
      end
   task automatic issue(input int d, input logic we, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input bit push);
      int n;
      @(negedge clk);
      req_we[d] = we;
      req_addr[d] = a;
      req_size[d] = sz;
      req_unsigned[d] = u;
      req_wdata[d] = wd;
      req_valid[d] = 1'b1;
      if (push) begin
         if (d == 0) q0.push_back('{rdata: er, err: ee});
         else q1.push_back('{rdata: er, err: ee});
      end
      n = 0;
      while (!req_ready[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: got req_ready=0 for 50 cycles, required 1");
      end
      @(posedge clk);
      #1 req_valid[d] = 1'b0;
   endtask
   task automatic drain(input int d);
      int n;
      n = 0;
      while ((d == 0 ? q0.size() : q1.size()) != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (n >= 100) begin
         n_chk++;
         n_fail++;
         $display("FAIL rsp_timeout: got no response in 100 cycles, required one");
      end
   endtask
   task automatic xact(input int d, input logic we, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd, input logic [31:0] er, input logic ee);
      issue(d, we, a, sz, u, wd, er, ee, 1'b1);
      drain(d);
   endtask
   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of test, required finish");
      $fatal(1);
   end
   initial begin
      int lat;
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0;
         req_valid[d] = 1'b0;
         req_we[d] = 1'b0;
         req_addr[d] = '0;
         req_size[d] = '0;
         req_unsigned[d] = 1'b0;
         req_wdata[d] = '0;
         rsp_ready[d] = 1'b1;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      #1;
      chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[0], 32'd0);
      chk("rst_rsp_err", 32'(rsp_err[0]), 32'd0);
      chk("rst3_req_ready", 32'(req_ready[1]), 32'd1);
      issue(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
      chk("lat0_accept", 32'(rsp_valid[0]), 32'd0);
      @(posedge clk);
      #1 chk("lat0_valid", 32'(rsp_valid[0]), 32'd1);
      drain(0);
      xact(0, 1'b1, 32'h21, 2'b00, 1'b0, 32'h000000A5, 32'h0, 1'b0);
      xact(0, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'hDEADA5EF, 1'b0);
      xact(0, 1'b0, 32'h21, 2'b00, 1'b0, 32'h0, 32'hFFFFFFA5, 1'b0);
      xact(0, 1'b0, 32'h21, 2'b00, 1'b1, 32'h0, 32'h000000A5, 1'b0);
      xact(0, 1'b0, 32'h23, 2'b00, 1'b0, 32'h0, 32'hFFFFFFDE, 1'b0);
      xact(0, 1'b1, 32'h42, 2'b01, 1'b0, 32'h00008001, 32'h0, 1'b0);
      xact(0, 1'b0, 32'h42, 2'b01, 1'b0, 32'h0, 32'hFFFF8001, 1'b0);
      xact(0, 1'b0, 32'h42, 2'b01, 1'b1, 32'h0, 32'h00008001, 1'b0);
      xact(0, 1'b0, 32'h40, 2'b10, 1'b1, 32'h0, 32'h8001BEEF, 1'b0);
      xact(0, 1'b0, 32'h03, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
      xact(0, 1'b1, 32'h05, 2'b01, 1'b0, 32'h00001234, 32'h0, 1'b1);
      xact(0, 1'b0, 32'h00, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
      xact(0, 1'b0, 32'h400, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
      xact(0, 1'b1, 32'h400, 2'b10, 1'b0, 32'h11111111, 32'h0, 1'b1);
      xact(0, 1'b0, 32'h04, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
      xact(0, 1'b0, 32'h00, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
      xact(0, 1'b0, 32'h3FC, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
      rsp_ready[1] = 1'b0;
      issue(1, 1'b1, 32'h8, 2'b10, 1'b0, 32'h12345678, 32'h0, 1'b0, 1'b1);
      lat = 0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1 chk("busy3_req_ready", 32'(req_ready[1]), 32'd0);
         if (rsp_valid[1]) begin
            lat = c;
            break;
         end
      end
      chk("lat3", 32'(lat), 32'd4);
      repeat (4) begin
         @(posedge clk);
         #1;
         chk("hold3_valid", 32'(rsp_valid[1]), 32'd1);
         chk("hold3_err", 32'(rsp_err[1]), 32'd0);
         chk("hold3_req_ready", 32'(req_ready[1]), 32'd0);
      end
      rsp_ready[1] = 1'b1;
      drain(1);
      xact(1, 1'b0, 32'h8, 2'b10, 1'b0, 32'h0, 32'h12345678, 1'b0);
      issue(1, 1'b1, 32'hC, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1 rst_n[1] = 1'b0;
      #1;
      chk("arst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
      chk("arst_req_ready", 32'(req_ready[1]), 32'd1);
      @(negedge clk);
      rst_n[1] = 1'b1;
      xact(1, 1'b0, 32'hC, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
      xact(1, 1'b0, 32'h8, 2'b10, 1'b0, 32'h0, 32'h12345678, 1'b0);
      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
